k005297_bubwrfe_multi: RTL and testbench
========================================

# k005297_bubwrfe_multi

Parametrised bubble write front-end for the K005297 family. It serialises the muxed bubble data stream into a LANES-wide shift register on rotation-phase slots and latches one word per rotation. It drives the active-low bubble data outputs under a frame-length-aware output-enable state machine. It sits between the write data mux and the bubble memory drive pins, and generalises the fixed 2/4-bit front-end to N lanes, a programmable active-lane count, and automatic frame termination.

## Interface
- LANES, 4, physical output lanes (1..8)
- ROT_LEN, 20, length of rotation phase vector; must be a multiple of LANES
- SHIFT_OFS, 3, phase of slot 0; slot k at SHIFT_OFS + k*(ROT_LEN/LANES), mod ROT_LEN
- LATCH_PHASE, 0, phase at which shift register is copied to outlatch
- OEN_PHASE, 17, phase at which output enable may arm
- FLEN_W, 12, width of frame-length counter
---
- i_MCLK  in  1  master clock; only clock
- i_RST_n  in  1  reset; synchronous, active-low
- i_CLK2M_PCEN_n  in  1  clock enable, active low
- i_ROT_n  in  ROT_LEN  rotation phase, one-hot-low
- i_TST  in  1  1 = normal, 0 = test passthrough
- i_LANES_ACT  in  $clog2(LANES)+1  active lane count; 0 or >LANES means LANES
- i_FRAME_LEN  in  FLEN_W  words per frame; 0 = unlimited
- i_MUXED_BDO  in  1  serial write data
- i_MUXED_BDO_EN  in  1  write request
- i_SUPBD_END_n  in  1  supervisor end-of-write, active low
- i_TST_VEC  in  LANES  test-mode output vector
- o_BDOUT_n  out  LANES  bubble data out, active low
- o_BUSY  out  1  FSM not IDLE
- o_DONE  out  1  one-enable-cycle pulse on DRAIN->IDLE

## Operation
- Slot k (k < active lanes) shifts: sr <= {sr[LANES-2:0], i_MUXED_BDO}. Slots k >= active do nothing.
- At LATCH_PHASE, the top `active` bits of sr are latched MSB-aligned, and lower lanes are latched as 0. Active lane count is sampled only here, so a mid-frame change takes effect at the next word.
- FSM states:
  - IDLE → ARMED when i_MUXED_BDO_EN=1 and OEN_PHASE is low.
  - ARMED → ACTIVE at the next LATCH_PHASE. Word count resets to 0.
  - ACTIVE: increment word count at each LATCH_PHASE. Go to DRAIN when count reaches i_FRAME_LEN-1 (if nonzero) or when i_SUPBD_END_n=0.
  - DRAIN → IDLE at the next LATCH_PHASE, with o_DONE pulsed.
  - i_SUPBD_END_n=0 in ARMED → IDLE directly.
- Output enable = state ∈ {ACTIVE, DRAIN}.
- o_BDOUT_n = i_TST ? ~(outlatch & {LANES{oen}}) : i_TST_VEC.
- Simultaneous events:
  - End and arm in the same cycle: end wins, stay IDLE.
  - Frame-length hit and end in the same cycle: a single transition to DRAIN.
- Counter saturates at all-ones in unlimited mode and never wraps.
- Rotation vector not one-hot: each slot and phase acts independently.

## Timing
- All state changes happen on posedge i_MCLK with i_CLK2M_PCEN_n=0.
- Reset is applied on any i_MCLK edge where i_RST_n=0, regardless of enable. Reset values:
  - sr=0, outlatch=0, count=0, state IDLE
  - o_BDOUT_n all 1 (normal mode), o_BUSY=0, o_DONE=0
- o_BDOUT_n is combinational from registers plus i_TST/i_TST_VEC; other outputs are registered.
- Data bit shifted at slot k appears on pins after the next LATCH_PHASE enable edge (latency ≤ one rotation).
- Output is enabled from the first latch after ARMED through the DRAIN latch edge: exactly i_FRAME_LEN words for a nonzero length.
- Reset mid-frame: pins release to all-1 on the reset edge, and no o_DONE is issued.

## Structure
- Package k005297_bubwr_pkg holds:
  - state enum (IDLE, ARMED, ACTIVE, DRAIN)
  - function slot_phase(k) computing SHIFT_OFS + k*(ROT_LEN/LANES) mod ROT_LEN
  - function clamp_lanes
- Sub-module k005297_bubwr_oenfsm holds the FSM and frame counter, and exports oen, busy and done.
- The top level holds the shift register, outlatch and output mux.

## Test plan
- Defaults, active lanes 4, bits 1,0,1,1 at phases 3,8,13,18, armed → o_BDOUT_n=4'b0100 after LATCH_PHASE.
- Active lanes 2, bits 1,1 at phases 3,8 → latch {1,1,0,0}, o_BDOUT_n=4'b0011; phases 13,18 do not shift.
- i_FRAME_LEN=3, EN held → exactly 3 words enabled, o_DONE pulses once, then o_BDOUT_n=4'hF.
- i_SUPBD_END_n=0 in the same cycle as arm → stays IDLE, o_BUSY=0; when asserted in ACTIVE → one DRAIN word then IDLE.
- i_TST=0, i_TST_VEC=4'b1010 → o_BDOUT_n=4'b1010 in every FSM state.
- LANES=8, ROT_LEN=40: slots at 3,8,...,38 fill all 8 lanes. Reset mid-ACTIVE → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/k005297_bubwr_pkg.sv
// Shared types and helpers for the K005297 bubble write front-end.
// Lane/slot arithmetic lives here so top and FSM agree on it.
package k005297_bubwr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } bubwr_state_t;

    // Rotation phase at which shift slot k fires.
    function automatic int slot_phase(input int k, input int ofs,
                                      input int rot_len, input int lanes);
        return (ofs + k * (rot_len / lanes)) % rot_len;
    endfunction

    // Zero or out-of-range lane counts select every physical lane.
    function automatic int clamp_lanes(input int act, input int lanes);
        return (act == 0 || act > lanes) ? lanes : act;
    endfunction

endpackage

// File: rtl/k005297_bubwr_oenfsm.sv
// Output-enable state machine and frame word counter.
// Arms on a write request, runs one frame, drains one word.
module k005297_bubwr_oenfsm
    import k005297_bubwr_pkg::*;
#(
    parameter int FLEN_W = 12
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_EN,
    input  logic              i_LATCH,
    input  logic              i_OEN_PH,
    input  logic              i_REQ,
    input  logic              i_END_n,
    input  logic [FLEN_W-1:0] i_FRAME_LEN,
    output logic              o_OEN,
    output logic              o_BUSY,
    output logic              o_DONE
);

    bubwr_state_t      state;
    bubwr_state_t      nxt;
    logic [FLEN_W-1:0] cnt;
    logic              hit;

    assign hit = (i_FRAME_LEN != '0) &&
                 (cnt == i_FRAME_LEN - FLEN_W'(1));

    // Next-state decode; end requests take priority over arming.
    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:   if (i_REQ && i_OEN_PH && i_END_n) nxt = ST_ARMED;
            ST_ARMED:  if (!i_END_n)                     nxt = ST_IDLE;
                       else if (i_LATCH)                 nxt = ST_ACTIVE;
            ST_ACTIVE: if (hit || !i_END_n)              nxt = ST_DRAIN;
            ST_DRAIN:  if (i_LATCH)                      nxt = ST_IDLE;
            default:                                     nxt = ST_IDLE;
        endcase
    end

    // State, saturating word counter and registered status outputs.
    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            o_OEN  <= 1'b0;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b0;
        end else if (i_EN) begin
            state  <= nxt;
            o_OEN  <= (nxt == ST_ACTIVE) || (nxt == ST_DRAIN);
            o_BUSY <= (nxt != ST_IDLE);
            o_DONE <= (state == ST_DRAIN) && (nxt == ST_IDLE);
            if (state == ST_ARMED && nxt == ST_ACTIVE)
                cnt <= '0;
            else if (state == ST_ACTIVE && i_LATCH && cnt != '1)
                cnt <= cnt + FLEN_W'(1);
        end
    end

endmodule

// File: rtl/k005297_bubwrfe_multi.sv
// N-lane bubble write front-end: serial-to-lane shifter,
// per-rotation output latch and active-low pin drive.
module k005297_bubwrfe_multi
    import k005297_bubwr_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ROT_LEN     = 20,
    parameter int SHIFT_OFS   = 3,
    parameter int LATCH_PHASE = 0,
    parameter int OEN_PHASE   = 17,
    parameter int FLEN_W      = 12
) (
    input  logic                       i_MCLK,
    input  logic                       i_RST_n,
    input  logic                       i_CLK2M_PCEN_n,
    input  logic [ROT_LEN-1:0]         i_ROT_n,
    input  logic                       i_TST,
    input  logic [$clog2(LANES):0]     i_LANES_ACT,
    input  logic [FLEN_W-1:0]          i_FRAME_LEN,
    input  logic                       i_MUXED_BDO,
    input  logic                       i_MUXED_BDO_EN,
    input  logic                       i_SUPBD_END_n,
    input  logic [LANES-1:0]           i_TST_VEC,
    output logic [LANES-1:0]           o_BDOUT_n,
    output logic                       o_BUSY,
    output logic                       o_DONE
);

    localparam int AW = $clog2(LANES) + 1;

    logic             en;
    logic             latch;
    logic             oen;
    logic [LANES-1:0] sr;
    logic [LANES-1:0] sr_nxt;
    logic [LANES-1:0] outlatch;
    logic [AW-1:0]    act_q;

    assign en    = ~i_CLK2M_PCEN_n;
    assign latch = ~i_ROT_n[LATCH_PHASE];

    // Every firing slot within the active count shifts in one bit.
    always_comb begin
        sr_nxt = sr;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(act_q) &&
                !i_ROT_n[slot_phase(k, SHIFT_OFS, ROT_LEN, LANES)])
                sr_nxt = (sr_nxt << 1) | LANES'(i_MUXED_BDO);
        end
    end

    // Shift register, MSB-aligned word latch and lane-count sample.
    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            sr       <= '0;
            outlatch <= '0;
            act_q    <= AW'(LANES);
        end else if (en) begin
            sr <= sr_nxt;
            if (latch) begin
                outlatch <= sr << (LANES - int'(act_q));
                act_q    <= AW'(clamp_lanes(int'(i_LANES_ACT), LANES));
            end
        end
    end

    k005297_bubwr_oenfsm #(
        .FLEN_W (FLEN_W)
    ) u_oenfsm (
        .i_MCLK      (i_MCLK),
        .i_RST_n     (i_RST_n),
        .i_EN        (en),
        .i_LATCH     (latch),
        .i_OEN_PH    (~i_ROT_n[OEN_PHASE]),
        .i_REQ       (i_MUXED_BDO_EN),
        .i_END_n     (i_SUPBD_END_n),
        .i_FRAME_LEN (i_FRAME_LEN),
        .o_OEN       (oen),
        .o_BUSY      (o_BUSY),
        .o_DONE      (o_DONE)
    );

    assign o_BDOUT_n = i_TST ? ~(outlatch & {LANES{oen}}) : i_TST_VEC;

endmodule

// File: tb/tb_k005297_bubwrfe_multi.sv
// Directed bench for the bubble write front-end: a 4-lane and
// an 8-lane instance driven by a shared word-level stimulus task.
module tb_k005297_bubwrfe_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen_n;
    logic [19:0] rot4;
    logic [39:0] rot8;
    logic        tst;
    logic [2:0]  lanes_a;
    logic [3:0]  lanes_b;
    logic [11:0] flen;
    logic        bdo;
    logic        req;
    logic        end_n;
    logic [3:0]  tvec_a;
    logic [7:0]  tvec_b;
    logic [3:0]  bd_a;
    logic [7:0]  bd_b;
    logic        busy_a, done_a, busy_b, done_b;

    logic [3:0]  mid_bd;
    logic        mid_busy;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    k005297_bubwrfe_multi u_a (
        .i_MCLK         (clk),
        .i_RST_n        (rst_n),
        .i_CLK2M_PCEN_n (pcen_n),
        .i_ROT_n        (rot4),
        .i_TST          (tst),
        .i_LANES_ACT    (lanes_a),
        .i_FRAME_LEN    (flen),
        .i_MUXED_BDO    (bdo),
        .i_MUXED_BDO_EN (req),
        .i_SUPBD_END_n  (end_n),
        .i_TST_VEC      (tvec_a),
        .o_BDOUT_n      (bd_a),
        .o_BUSY         (busy_a),
        .o_DONE         (done_a)
    );

    k005297_bubwrfe_multi #(.LANES(8), .ROT_LEN(40)) u_b (
        .i_MCLK         (clk),
        .i_RST_n        (rst_n),
        .i_CLK2M_PCEN_n (pcen_n),
        .i_ROT_n        (rot8),
        .i_TST          (tst),
        .i_LANES_ACT    (lanes_b),
        .i_FRAME_LEN    (flen),
        .i_MUXED_BDO    (bdo),
        .i_MUXED_BDO_EN (req),
        .i_SUPBD_END_n  (end_n),
        .i_TST_VEC      (tvec_b),
        .o_BDOUT_n      (bd_b),
        .o_BUSY         (busy_b),
        .o_DONE         (done_b)
    );

    always @(negedge clk) if (done_a) done_cnt++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One rotation, phases 1..rl-1 then the latch phase 0.
    // Slot k carries w[nl-1-k]; end_n pulses low at phase endp.
    task automatic word(input int rl, input logic [7:0] w,
                        input int nl, input int endp);
        for (int i = 1; i <= rl; i++) begin
            int p;
            int sp;
            p  = i % rl;
            sp = rl / nl;
            rot4 = '1;
            rot8 = '1;
            if (rl == 20) rot4[p] = 1'b0;
            else          rot8[p] = 1'b0;
            bdo   = 1'b0;
            if (p >= 3 && (p - 3) % sp == 0)
                bdo = w[nl - 1 - (p - 3) / sp];
            end_n = (p == endp) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (p == 17) begin
                mid_bd   = bd_a;
                mid_busy = busy_a;
            end
        end
        rot4  = '1;
        rot8  = '1;
        end_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] lanes;
        logic [3:0] w;
        logic [3:0] bd;
        logic       busy;
    } vec_t;

    vec_t tv[10];

    initial begin
        tv[0] = '{3'd4, 4'b1011, 4'b0100, 1'b1};
        tv[1] = '{3'd2, 4'b1101, 4'b0010, 1'b1};
        tv[2] = '{3'd2, 4'b1110, 4'b0011, 1'b1};
        tv[3] = '{3'd0, 4'b0110, 4'b1011, 1'b1};
        tv[4] = '{3'd7, 4'b1001, 4'b0110, 1'b1};
        tv[5] = '{3'd1, 4'b0101, 4'b1010, 1'b1};
        tv[6] = '{3'd1, 4'b1000, 4'b0111, 1'b1};
        tv[7] = '{3'd4, 4'b0111, 4'b1111, 1'b1};
        tv[8] = '{3'd3, 4'b0010, 4'b1101, 1'b1};
        tv[9] = '{3'd3, 4'b1011, 4'b0101, 1'b1};

        rst_n = 1'b0; pcen_n = 1'b0; rot4 = '1; rot8 = '1;
        tst = 1'b1; lanes_a = 3'd4; lanes_b = 4'd8; flen = '0;
        bdo = 1'b0; req = 1'b0; end_n = 1'b1;
        tvec_a = 4'b1010; tvec_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bd_a", bd_a, 4'hF);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_bd_b", bd_b, 8'hFF);
        rst_n = 1'b1;

        // Unlimited frame, lane count varied per word.
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lanes_a = tv[i].lanes;
            word(20, {4'b0, tv[i].w}, 4, -1);
            chk($sformatf("vec%0d_bd", i), bd_a, tv[i].bd);
            chk($sformatf("vec%0d_busy", i), busy_a, tv[i].busy);
        end

        // Supervisor end while ACTIVE: one drain word.
        lanes_a = 3'd4; req = 1'b0;
        word(20, 8'h0F, 4, 5);
        chk("endact_mid_bd", mid_bd, 4'b0101);
        chk("endact_mid_busy", mid_busy, 1);
        chk("endact_bd", bd_a, 4'hF);
        chk("endact_busy", busy_a, 0);
        chk("endact_done", done_a, 1);

        // End coincident with arm: stays idle.
        req = 1'b1;
        word(20, 8'h0F, 4, 17);
        chk("armend_mid_busy", mid_busy, 0);
        chk("armend_busy", busy_a, 0);
        chk("armend_bd", bd_a, 4'hF);

        // End while ARMED: straight back to idle.
        word(20, 8'h0F, 4, 18);
        chk("endarm_mid_busy", mid_busy, 1);
        chk("endarm_mid_bd", mid_bd, 4'hF);
        chk("endarm_busy", busy_a, 0);
        chk("endarm_donecnt", done_cnt, 1);

        // Three-word frame with request held.
        flen = 12'd3;
        word(20, 8'h01, 4, -1);
        chk("fl_w0", bd_a, 4'b1110);
        word(20, 8'h02, 4, -1);
        chk("fl_w1", bd_a, 4'b1101);
        word(20, 8'h04, 4, -1);
        chk("fl_w2", bd_a, 4'b1011);
        chk("fl_busy2", busy_a, 1);
        word(20, 8'h08, 4, -1);
        chk("fl_drain_bd", mid_bd, 4'b1011);
        chk("fl_drain_busy", mid_busy, 1);
        chk("fl_end_bd", bd_a, 4'hF);
        chk("fl_end_busy", busy_a, 0);
        chk("fl_done", done_a, 1);
        req = 1'b0; flen = '0;

        // Test passthrough across all states.
        tst = 1'b0;
        #1;
        chk("tst_idle", bd_a, 4'b1010);
        req = 1'b1;
        word(20, 8'h00, 4, -1);
        chk("tst_armed", mid_bd, 4'b1010);
        chk("tst_armed_busy", mid_busy, 1);
        chk("tst_active", bd_a, 4'b1010);
        req = 1'b0;
        word(20, 8'h00, 4, 5);
        chk("tst_drain", mid_bd, 4'b1010);
        chk("tst_drain_busy", mid_busy, 1);
        chk("tst_idle2", bd_a, 4'b1010);
        chk("tst_idle2_busy", busy_a, 0);
        tst = 1'b1;

        // Arm, check enable gating, fill 8 lanes, then reset.
        req = 1'b1;
        word(20, 8'h03, 4, -1);
        chk("pre_rst_bd", bd_a, 4'b1100);
        pcen_n = 1'b1;
        word(20, 8'h0F, 4, 5);
        chk("gated_bd", bd_a, 4'b1100);
        chk("gated_busy", busy_a, 1);
        pcen_n = 1'b0;
        word(40, 8'hB2, 8, -1);
        chk("b8_bd", bd_b, 8'h4D);
        chk("b8_busy", busy_b, 1);
        chk("b8_a_hold", bd_a, 4'b1100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_bd_a", bd_a, 4'hF);
        chk("mrst_busy_a", busy_a, 0);
        chk("mrst_done_a", done_a, 0);
        chk("mrst_bd_b", bd_b, 8'hFF);
        chk("mrst_busy_b", busy_b, 0);
        chk("mrst_done_b", done_b, 0);
        chk("done_total", done_cnt, 3);
        rst_n = 1'b1; req = 1'b0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
